// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forwarding-select encodings, the controller FSM state type,
// the shadow-pipeline entry layout and the register-match helper.
package hazard_pkg;

  localparam int unsigned REG_W = 4;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [REG_W-1:0] PC_REG   = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             rf_e;
    logic             load;
  } shadow_t;

  localparam shadow_t BUBBLE = '0;

  // True when a used source register will be written by the given entry.
  // The PC register is never produced through the pipeline, so it never hits.
  function automatic logic reg_hit(input logic             used,
                                   input logic [REG_W-1:0] src,
                                   input shadow_t          e);
    return used && (src != PC_REG) && e.valid && e.rf_e && (src == e.rd);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source select for one ID-stage operand.
// Ports:
//   used      - operand is actually read by the ID instruction
//   src       - operand register number
//   ex/mem/wb - shadow pipeline entries
//   sel       - operand source (RF / EX / MEM / WB), combinational
module fwd_select
  import hazard_pkg::*;
(
  input  logic             used,
  input  logic [REG_W-1:0] src,
  input  shadow_t          ex,
  input  shadow_t          mem,
  input  shadow_t          wb,
  output logic [FWD_W-1:0] sel
);

  // Youngest producer wins; a load in EX has no result yet, so skip it.
  always_comb begin
    sel = FWD_RF;
    if (reg_hit(used, src, ex) && !ex.load) begin
      sel = FWD_EX;
    end else if (reg_hit(used, src, mem)) begin
      sel = FWD_MEM;
    end else if (reg_hit(used, src, wb)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// operand forwarding, driven by a 3-entry shadow of EX/MEM/WB.
// Ports:
//   clk, reset                 - clock, synchronous active-low reset
//   id_valid                   - ID instruction is real (not a bubble)
//   id_rn/id_rm/id_rd          - ID register numbers
//   id_use_rn/rm/rd            - which of those registers are read
//   id_rf_e, id_load           - ID instruction writes the RF / is a load
//   br_taken                   - ID branch resolved taken this cycle
//   enable_pc, enable_ifid     - PC and IF/ID load enables
//   S                          - 1 forces NOP controls into ID/EX
//   ifid_flush                 - IF/ID loads a zero instruction
//   fwd_a/fwd_b/fwd_c          - operand sources for rn/rm/rd
//   stall_cnt, flush_cnt       - saturating event counters
module hazard_control
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             br_taken,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             S,
  output logic             ifid_flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [FWD_W-1:0] fwd_c,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t  state;
  state_t  state_next;
  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;
  shadow_t id_entry;

  logic id_live;
  logic src_hit;
  logic stall;
  logic issue;
  logic branch_go;

  // The slot behind a taken branch is dead, so FLUSH masks the ID instruction.
  assign id_live = id_valid && (state == RUN);

  assign src_hit = reg_hit(id_use_rn, id_rn, ex_q)
                || reg_hit(id_use_rm, id_rm, ex_q)
                || reg_hit(id_use_rd, id_rd, ex_q);

  assign stall     = id_live && ex_q.load && src_hit;
  assign issue     = id_live && !stall;
  assign branch_go = (state == RUN) && br_taken && !stall;

  assign id_entry = '{valid: 1'b1, rd: id_rd, rf_e: id_rf_e, load: id_load};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pipeline control; a stall holds the branch for a retry.
  always_comb begin
    state_next  = state;
    enable_pc   = 1'b1;
    enable_ifid = 1'b1;
    S           = 1'b0;
    ifid_flush  = 1'b0;
    unique case (state)
      RUN: begin
        if (stall) begin
          enable_pc   = 1'b0;
          enable_ifid = 1'b0;
          S           = 1'b1;
        end else if (br_taken) begin
          ifid_flush = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        S          = 1'b1;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Shadow pipeline advances every cycle; non-issuing cycles insert a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= issue ? id_entry : BUBBLE;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Event counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branch_go && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  fwd_select u_fwd_a (
    .used (id_use_rn),
    .src  (id_rn),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (fwd_a)
  );

  fwd_select u_fwd_b (
    .used (id_use_rm),
    .src  (id_rm),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (fwd_b)
  );

  fwd_select u_fwd_c (
    .used (id_use_rd),
    .src  (id_rd),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (fwd_c)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control.
module tb_hazard_control;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_rn;
  logic [3:0]  id_rm;
  logic [3:0]  id_rd;
  logic        id_use_rn;
  logic        id_use_rm;
  logic        id_use_rd;
  logic        id_rf_e;
  logic        id_load;
  logic        br_taken;
  logic        enable_pc;
  logic        enable_ifid;
  logic        S;
  logic        ifid_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  fwd_c;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int tests;
  int fails;

  hazard_control dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .id_use_rn   (id_use_rn),
    .id_use_rm   (id_use_rm),
    .id_use_rd   (id_use_rd),
    .id_rf_e     (id_rf_e),
    .id_load     (id_load),
    .br_taken    (br_taken),
    .enable_pc   (enable_pc),
    .enable_ifid (enable_ifid),
    .S           (S),
    .ifid_flush  (ifid_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .fwd_c       (fwd_c),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven after this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rd, input logic urn, input logic urm,
                       input logic urd, input logic rfe, input logic ld,
                       input logic br);
    id_valid  = v;
    id_rn     = rn;
    id_rm     = rm;
    id_rd     = rd;
    id_use_rn = urn;
    id_use_rm = urm;
    id_use_rd = urd;
    id_rf_e   = rfe;
    id_load   = ld;
    br_taken  = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic ifid,
                          input logic s_exp, input logic fl);
    chk({tag, ".enable_pc"},   16'(enable_pc),   16'(pc));
    chk({tag, ".enable_ifid"}, 16'(enable_ifid), 16'(ifid));
    chk({tag, ".S"},           16'(S),           16'(s_exp));
    chk({tag, ".ifid_flush"},  16'(ifid_flush),  16'(fl));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    idle();

    // Reset state.
    tick();
    reset = 1'b1;
    #1;
    chk_ctrl("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset.fwd_a", 16'(fwd_a), 16'd0);
    chk("reset.fwd_b", 16'(fwd_b), 16'd0);
    chk("reset.fwd_c", 16'(fwd_c), 16'd0);
    chk("reset.stall_cnt", stall_cnt, 16'd0);
    chk("reset.flush_cnt", flush_cnt, 16'd0);

    // Load-use: LDR r2 then ADD r3,r2,r4.
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ldr.enable_pc", 16'(enable_pc), 16'd1);
    tick();
    drive(1'b1, 4'd2, 4'd4, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("lu_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lu_stall.fwd_a", 16'(fwd_a), 16'd0);
    tick();
    #1;
    chk_ctrl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_after.fwd_a", 16'(fwd_a), 16'b10);
    chk("lu_after.fwd_b", 16'(fwd_b), 16'b00);
    chk("lu_after.stall_cnt", stall_cnt, 16'd1);
    tick();

    // ALU chain on r5: EX, MEM, WB, then register file.
    drive(1'b1, 4'd1, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd7, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("alu_ex.enable_pc", 16'(enable_pc), 16'd1);
    chk("alu_ex.fwd_b", 16'(fwd_b), 16'b01);
    tick();
    drive(1'b1, 4'd0, 4'd5, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("alu_mem.fwd_b", 16'(fwd_b), 16'b10);
    tick();
    drive(1'b1, 4'd0, 4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("alu_wb.fwd_b", 16'(fwd_b), 16'b11);
    tick();
    // Store of r6 (now in WB) while r5 has retired.
    drive(1'b1, 4'd0, 4'd5, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("alu_rf.fwd_b", 16'(fwd_b), 16'b00);
    chk("store.fwd_c", 16'(fwd_c), 16'b11);
    tick();

    // Taken branch, second br_taken during FLUSH ignored, ID masked.
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctrl("br", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_ctrl("br_flush", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("br_flush.flush_cnt", flush_cnt, 16'd1);
    tick();
    drive(1'b1, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("br_back", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("br_back.flush_cnt", flush_cnt, 16'd1);
    tick();

    // Branch coincident with load-use: stall first, branch retried.
    drive(1'b1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctrl("sim_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    chk("sim.flush_cnt", flush_cnt, 16'd1);
    chk("sim.stall_cnt", stall_cnt, 16'd2);
    chk_ctrl("sim_br", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sim_br.fwd_a", 16'(fwd_a), 16'b10);
    tick();
    idle();
    chk("sim_flush.S", 16'(S), 16'd1);
    chk("sim_flush.flush_cnt", flush_cnt, 16'd2);
    tick();

    // R15 never stalls or forwards.
    drive(1'b1, 4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd15, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r15_ld.enable_pc", 16'(enable_pc), 16'd1);
    chk("r15_ld.fwd_a", 16'(fwd_a), 16'b00);
    tick();
    drive(1'b1, 4'd0, 4'd15, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r15_alu.fwd_b", 16'(fwd_b), 16'b00);
    tick();

    // Reset during FLUSH with a loaded shadow pipe.
    drive(1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    chk("rst_pre.S", 16'(S), 16'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b1, 4'd2, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mid.fwd_a", 16'(fwd_a), 16'd0);
    chk("rst_mid.fwd_b", 16'(fwd_b), 16'd0);
    chk("rst_mid.fwd_c", 16'(fwd_c), 16'd0);
    chk("rst_mid.stall_cnt", stall_cnt, 16'd0);
    chk("rst_mid.flush_cnt", flush_cnt, 16'd0);
    tick();

    // Stall counter saturation.
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    drive(1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat1.enable_pc", 16'(enable_pc), 16'd0);
    tick();
    #1;
    chk("sat1.stall_cnt", stall_cnt, 16'hFFFF);
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat2.enable_pc", 16'(enable_pc), 16'd0);
    tick();
    #1;
    chk("sat2.stall_cnt", stall_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports clk and reset; reset=0 at a rising clk edge resets the block.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 id_valid  input  1  the ID-stage instruction is real, not a NOP or bubble.
REQ-005 id_rn, id_rm, id_rd  input  4 each  ID-stage source/destination register numbers.
REQ-006 id_use_rn, id_use_rm, id_use_rd  input  1 each  the matching register is read (id_use_rd is the store data read).
REQ-007 id_rf_e, id_load  input  1 each  the ID instruction writes the register file / is a load.
REQ-008 br_taken  input  1  the ID-stage branch is resolved taken this cycle.
REQ-009 enable_pc, enable_ifid  output  1 each  PC and IF/ID register load enables.
REQ-010 S  output  1  control-mux select; 1 substitutes zero (NOP) controls into ID/EX.
REQ-011 ifid_flush  output  1  IF/ID loads an all-zero instruction at the next edge.
REQ-012 fwd_a, fwd_b, fwd_c  output  2 each  operand source for rn, rm, rd: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-013 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-014 The block SHALL keep a shadow pipeline of three entries (EX, MEM, WB); each entry is {valid, rd[3:0], rf_e, load}.
REQ-015 Every edge SHALL shift the shadow pipeline: WB<=MEM, MEM<=EX, EX<=the ID entry if issue=1, else a bubble (all fields 0).
REQ-016 issue SHALL equal id_valid & ~stall & (state==RUN).
REQ-017 stall SHALL be combinational: id_valid & EX.valid & EX.load & EX.rf_e & (source match).
REQ-018 Source match is any used source register equal to EX.rd; register 15 never matches.
REQ-019 While stall=1: enable_pc=0, enable_ifid=0, S=1, ifid_flush=0; the stall lasts exactly one cycle per load-use pair.
REQ-020 FSM states SHALL be RUN and FLUSH.
REQ-021 RUN->FLUSH when br_taken=1 and stall=0; FLUSH->RUN unconditionally after one cycle.
REQ-022 If br_taken and stall are both 1, stall wins, br_taken is ignored and no transition occurs (the branch re-presents next cycle).
REQ-023 In the branch cycle: ifid_flush=1, enable_pc=1, enable_ifid=1, S=0.
REQ-024 In FLUSH: id_valid is treated as 0, so the ID entry becomes a bubble, S=1, enable_pc=1, enable_ifid=1, ifid_flush=0.
REQ-025 br_taken received while in FLUSH SHALL be ignored.
REQ-026 Default (RUN, no event): enable_pc=1, enable_ifid=1, S=0, ifid_flush=0.
REQ-027 Forwarding SHALL be combinational for each used operand with register != 15.
REQ-028 Forwarding priority: EX (valid, rf_e, ~load, rd match) ->01, else MEM (valid, rf_e) ->10, else WB (valid, rf_e) ->11, else 00.
REQ-029 An unused operand SHALL select 00.
REQ-030 stall_cnt SHALL increment on each stall cycle; flush_cnt SHALL increment on each RUN->FLUSH transition.
REQ-031 Both counters SHALL saturate at 16'hFFFF with no wrap-around.

Reset
REQ-032 On reset=0 at an edge: state=RUN, all shadow entries=bubble, both counters=0.
REQ-033 This applies mid-stall or mid-FLUSH with no residual flush or stall.
REQ-034 After the reset edge, outputs SHALL be enable_pc=1, enable_ifid=1, S=0, ifid_flush=0, fwd_*=00.

Structure
REQ-035 Package hazard_pkg SHALL hold the fwd encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), the state enum {RUN, FLUSH}, the shadow entry struct, and the constant PC_REG=4'hF.
REQ-036 A sub-module fwd_select (one operand, priority logic of REQ-028) SHALL be instantiated three times.

Verification
REQ-037 Load-use: LDR r2 issued, then ADD using r2 -> exactly one stall cycle (enable_pc=0, S=1), then fwd_a=10; stall_cnt=1.
REQ-038 ALU chain: ADD r5 followed by SUB reading r5 as rm -> no stall, fwd_b=01; the next reader of r5 gets 10, then 11, then 00.
REQ-039 Branch: br_taken=1 in RUN -> ifid_flush=1 that cycle, S=1 the next cycle, flush_cnt=1; a second br_taken during FLUSH is ignored.
REQ-040 Simultaneous: br_taken=1 with a load-use hazard -> stall only, state stays RUN; br_taken held the next cycle -> FLUSH.
REQ-041 R15: ID reads r15 while EX.rd=15, rf_e=1 -> fwd=00, no stall.
REQ-042 Reset: reset=0 during FLUSH with a loaded shadow pipe -> next cycle all defaults, counters 0; saturation: preload stall_cnt to 16'hFFFF, then stall -> stays 16'hFFFF.
